nv_nvdla_cdp_dp_mul_fork: RTL



---
 rtl/nv_nvdla_cdp_dp_mul_fork.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nv_nvdla_cdp_dp_mul_fork.sv
// CDP lazy fork: one input beat feeds the LUT output register and a delay FIFO.
// The FIFO bounds LUT-path run-ahead to DEPTH beats ahead of the multiplier operand.
module nv_nvdla_cdp_dp_mul_fork #(
    parameter int THROUGHPUT = 4,
    parameter int ICVTO_BWPE = 9,
    parameter int DEPTH      = 16
) (
    input  logic                             nvdla_core_clk,
    input  logic                             nvdla_core_rstn,
    input  logic [THROUGHPUT*ICVTO_BWPE-1:0] cvt2fork_pd,
    input  logic                             cvt2fork_pvld,
    output logic                             cvt2fork_prdy,
    output logic [THROUGHPUT*ICVTO_BWPE-1:0] fork2lut_pd,
    output logic                             fork2lut_pvld,
    input  logic                             fork2lut_prdy,
    output logic [THROUGHPUT*ICVTO_BWPE-1:0] sync2mul_pd,
    output logic                             sync2mul_pvld,
    input  logic                             sync2mul_prdy,
    output logic [$clog2(DEPTH):0]           fifo_cnt
);

    localparam int PW = THROUGHPUT * ICVTO_BWPE;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic          lut_vld;
    logic [PW-1:0] lut_pd;
    logic          head_vld;
    logic [PW-1:0] head_pd;

    logic          lut_free;
    logic          push;
    logic          pop;
    logic          head_from_in;
    logic          head_from_mem;

    assign lut_free      = !lut_vld | fork2lut_prdy;
    assign cvt2fork_prdy = nvdla_core_rstn & lut_free & (cnt < FULL);
    assign push          = cvt2fork_pvld & cvt2fork_prdy;
    assign pop           = head_vld & sync2mul_prdy;
    assign rd_nxt        = rd_ptr + 1'b1;

    assign fork2lut_pd   = lut_pd;
    assign fork2lut_pvld = lut_vld;
    assign sync2mul_pd   = head_pd;
    assign sync2mul_pvld = head_vld;
    assign fifo_cnt      = cnt;

    // Occupancy and head-register source selection for the next cycle.
    always_comb begin
        cnt_nxt       = cnt;
        head_from_in  = 1'b0;
        head_from_mem = 1'b0;
        if (push && !pop) begin
            cnt_nxt = cnt + ONE;
        end else if (pop && !push) begin
            cnt_nxt = cnt - ONE;
        end
        if (push && ((cnt == '0) || (pop && cnt == ONE))) begin
            head_from_in = 1'b1;
        end else if (pop && cnt > ONE) begin
            head_from_mem = 1'b1;
        end
    end

    // LUT branch output register: load on transfer, clear on drain.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            lut_vld <= 1'b0;
        end else if (push) begin
            lut_vld <= 1'b1;
        end else if (fork2lut_prdy) begin
            lut_vld <= 1'b0;
        end
    end

    // LUT branch data: not reset, qualified by lut_vld.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            lut_pd <= cvt2fork_pd;
        end
    end

    // FIFO control: pointers, occupancy and head valid.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            cnt      <= cnt_nxt;
            head_vld <= (cnt_nxt != '0);
        end
    end

    // FIFO storage: every accepted beat is written at the tail.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr] <= cvt2fork_pd;
        end
    end

    // Registered read of the head entry; bypass the input when the FIFO drains.
    always_ff @(posedge nvdla_core_clk) begin
        if (head_from_in) begin
            head_pd <= cvt2fork_pd;
        end else if (head_from_mem) begin
            head_pd <= mem[rd_nxt];
        end
    end

endmodule
